// File: rtl/bus_master.sv
// Single-outstanding initiator for the 8-entry register-file bus.
// Takes read/write commands on a valid/ready port and returns read data on a valid/ready response port.
module bus_master #(
    parameter int AW    = 3,
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WRITE,
    input  logic [AW-1:0]    CMD_ADDR,
    input  logic [DW-1:0]    CMD_WDATA,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [DW-1:0]    RSP_DATA,
    output logic [AW-1:0]    BUS_ADDR,
    output logic [DW-1:0]    BUS_DIN,
    input  logic [DW-1:0]    BUS_DOUT,
    output logic             BUS_WEN,
    output logic             BUS_OEN,
    output logic [CNT_W-1:0] WR_CNT,
    output logic [CNT_W-1:0] RD_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPT,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      din_q, din_d;
    logic               wen_q, wen_d;
    logic               oen_q, oen_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;

    assign CMD_READY = (state_q == IDLE) & ~RST;

    // Strobes are launched on the accept edge so they appear as registered
    // outputs in the cycle that the WR/RD_ISSUE state occupies.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        wen_d       = 1'b0;
        oen_d       = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        case (state_q)
            IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    addr_d = CMD_ADDR;
                    if (CMD_WRITE) begin
                        din_d   = CMD_WDATA;
                        wen_d   = 1'b1;
                        state_d = WR;
                    end else begin
                        oen_d   = 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR: begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
                state_d  = IDLE;
            end
            RD_ISSUE: begin
                state_d = RD_CAPT;
            end
            RD_CAPT: begin
                rsp_data_d  = BUS_DOUT;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    rd_cnt_d    = rd_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            wen_q       <= 1'b0;
            oen_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign BUS_ADDR  = addr_q;
    assign BUS_DIN   = din_q;
    assign BUS_WEN   = wen_q;
    assign BUS_OEN   = oen_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign WR_CNT    = wr_cnt_q;
    assign RD_CNT    = rd_cnt_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a register-file responder model;
// a second instance with CNT_W=4 exercises counter wrap.
module tb_bus_master;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [2:0]  CMD_ADDR;
    logic [7:0]  CMD_WDATA;
    logic        RSP_VALID, RSP_READY;
    logic [7:0]  RSP_DATA;
    logic [2:0]  BUS_ADDR;
    logic [7:0]  BUS_DIN;
    logic [7:0]  BUS_DOUT = 8'h00;
    logic        BUS_WEN, BUS_OEN;
    logic [15:0] WR_CNT, RD_CNT;

    logic        c4_valid, c4_ready, c4_rsp_valid;
    logic [7:0]  c4_rsp_data, c4_din;
    logic [2:0]  c4_bus_addr;
    logic        c4_wen, c4_oen;
    logic [3:0]  c4_wr_cnt, c4_rd_cnt;

    logic [7:0]  mem [8];
    int          wen_pulses = 0;
    int          oen_pulses = 0;
    bit          overlap = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 CLK = ~CLK;

    bus_master #(.AW(3), .DW(8), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN), .BUS_DOUT(BUS_DOUT),
        .BUS_WEN(BUS_WEN), .BUS_OEN(BUS_OEN),
        .WR_CNT(WR_CNT), .RD_CNT(RD_CNT)
    );

    bus_master #(.AW(3), .DW(8), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(c4_valid), .CMD_READY(c4_ready), .CMD_WRITE(1'b1),
        .CMD_ADDR(3'd1), .CMD_WDATA(8'h3C),
        .RSP_VALID(c4_rsp_valid), .RSP_READY(1'b1), .RSP_DATA(c4_rsp_data),
        .BUS_ADDR(c4_bus_addr), .BUS_DIN(c4_din), .BUS_DOUT(8'h00),
        .BUS_WEN(c4_wen), .BUS_OEN(c4_oen),
        .WR_CNT(c4_wr_cnt), .RD_CNT(c4_rd_cnt)
    );

    // Responder: writes on WEN, registered read data on OEN.
    always @(posedge CLK) begin
        if (BUS_WEN) mem[BUS_ADDR] <= BUS_DIN;
        if (BUS_OEN) BUS_DOUT <= mem[BUS_ADDR];
    end

    always @(negedge CLK) begin
        if (BUS_WEN) wen_pulses <= wen_pulses + 1;
        if (BUS_OEN) oen_pulses <= oen_pulses + 1;
        if (BUS_WEN && BUS_OEN) overlap <= 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        int w0;
        RST = 1'b1;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 3'd6; CMD_WDATA = 8'h66;
        #2;
        w0 = wen_pulses;
        tick; tick;
        checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", CMD_READY); end
        checks++; if ({BUS_WEN, BUS_OEN, BUS_ADDR, BUS_DIN} !== 13'd0) begin errors++; $display("FAIL rst_bus: got %0h expected 0", {BUS_WEN, BUS_OEN, BUS_ADDR, BUS_DIN}); end
        checks++; if ({RSP_VALID, RSP_DATA} !== 9'd0) begin errors++; $display("FAIL rst_rsp: got %0h expected 0", {RSP_VALID, RSP_DATA}); end
        checks++; if ({WR_CNT, RD_CNT} !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0h expected 0", {WR_CNT, RD_CNT}); end
        RST = 1'b0;
        #1;
        checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", CMD_READY); end
        checks++; if (wen_pulses !== w0) begin errors++; $display("FAIL rst_held_cmd: got %0d wen pulses expected %0d", wen_pulses, w0); end
        tick;
        CMD_VALID = 1'b0;
        checks++; if ({BUS_WEN, BUS_ADDR, BUS_DIN} !== {1'b1, 3'd6, 8'h66}) begin errors++; $display("FAIL rst_first_accept: got %0h expected %0h", {BUS_WEN, BUS_ADDR, BUS_DIN}, {1'b1, 3'd6, 8'h66}); end
        tick;
    endtask

    task automatic test_write;
        logic [15:0] wc;
        wc = WR_CNT;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 3'd3; CMD_WDATA = 8'hA5;
        tick;
        CMD_VALID = 1'b0;
        checks++; if ({BUS_WEN, BUS_OEN, BUS_ADDR, BUS_DIN} !== {2'b10, 3'd3, 8'hA5}) begin errors++; $display("FAIL wr_strobe: got %0h expected %0h", {BUS_WEN, BUS_OEN, BUS_ADDR, BUS_DIN}, {2'b10, 3'd3, 8'hA5}); end
        checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL wr_busy: got %b expected 0", CMD_READY); end
        tick;
        checks++; if ({BUS_WEN, CMD_READY} !== 2'b01) begin errors++; $display("FAIL wr_done: got %b expected 01", {BUS_WEN, CMD_READY}); end
        checks++; if (WR_CNT !== wc + 16'd1) begin errors++; $display("FAIL wr_cnt: got %0d expected %0d", WR_CNT, wc + 16'd1); end
        checks++; if ({BUS_ADDR, BUS_DIN} !== {3'd3, 8'hA5}) begin errors++; $display("FAIL wr_hold: got %0h expected %0h", {BUS_ADDR, BUS_DIN}, {3'd3, 8'hA5}); end
    endtask

    task automatic test_read;
        logic [15:0] rc;
        int o0;
        rc = RD_CNT; o0 = oen_pulses;
        RSP_READY = 1'b1;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 3'd3; CMD_WDATA = 8'h00;
        tick;
        CMD_VALID = 1'b0;
        checks++; if ({BUS_OEN, BUS_WEN, BUS_ADDR, RSP_VALID} !== {2'b10, 3'd3, 1'b0}) begin errors++; $display("FAIL rd_issue: got %0h expected %0h", {BUS_OEN, BUS_WEN, BUS_ADDR, RSP_VALID}, {2'b10, 3'd3, 1'b0}); end
        tick;
        checks++; if ({BUS_OEN, RSP_VALID} !== 2'b00) begin errors++; $display("FAIL rd_capt: got %b expected 00", {BUS_OEN, RSP_VALID}); end
        tick;
        checks++; if ({RSP_VALID, RSP_DATA, CMD_READY} !== {1'b1, 8'hA5, 1'b0}) begin errors++; $display("FAIL rd_resp: got %0h expected %0h", {RSP_VALID, RSP_DATA, CMD_READY}, {1'b1, 8'hA5, 1'b0}); end
        checks++; if (BUS_DIN !== 8'hA5) begin errors++; $display("FAIL rd_din_hold: got %0h expected a5", BUS_DIN); end
        tick;
        checks++; if ({RSP_VALID, CMD_READY} !== 2'b01) begin errors++; $display("FAIL rd_handshake: got %b expected 01", {RSP_VALID, CMD_READY}); end
        checks++; if (RD_CNT !== rc + 16'd1) begin errors++; $display("FAIL rd_cnt: got %0d expected %0d", RD_CNT, rc + 16'd1); end
        checks++; if (oen_pulses !== o0 + 1) begin errors++; $display("FAIL rd_oen_once: got %0d expected %0d", oen_pulses, o0 + 1); end
    endtask

    task automatic test_backpressure;
        logic [15:0] rc;
        int w0;
        rc = RD_CNT; w0 = wen_pulses;
        RSP_READY = 1'b0;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 3'd3;
        tick;
        CMD_WRITE = 1'b1; CMD_ADDR = 3'd5; CMD_WDATA = 8'h55;
        tick; tick;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if ({RSP_VALID, RSP_DATA, CMD_READY} !== {1'b1, 8'hA5, 1'b0}) begin errors++; $display("FAIL bp_hold[%0d]: got %0h expected %0h", i, {RSP_VALID, RSP_DATA, CMD_READY}, {1'b1, 8'hA5, 1'b0}); end
        end
        checks++; if (wen_pulses !== w0) begin errors++; $display("FAIL bp_no_accept: got %0d wen pulses expected %0d", wen_pulses, w0); end
        RSP_READY = 1'b1; CMD_VALID = 1'b0;
        tick;
        checks++; if ({RSP_VALID, CMD_READY} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b expected 01", {RSP_VALID, CMD_READY}); end
        tick;
        checks++; if ({RSP_VALID, RD_CNT} !== {1'b0, rc + 16'd1}) begin errors++; $display("FAIL bp_one_handshake: got %0h expected %0h", {RSP_VALID, RD_CNT}, {1'b0, rc + 16'd1}); end
    endtask

    task automatic test_back_to_back;
        int w0, o0, n, cyc;
        RST = 1'b1; tick; RST = 1'b0; #1;
        w0 = wen_pulses; o0 = oen_pulses; cyc = 0;
        RSP_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 3'(i); CMD_WDATA = 8'h10 + 8'(i);
            n = 0;
            while (!CMD_READY && n < 10) begin tick; n++; cyc++; end
            tick; cyc++;
        end
        CMD_VALID = 1'b0;
        tick;
        checks++; if (cyc !== 15) begin errors++; $display("FAIL b2b_wr_spacing: got %0d cycles expected 15", cyc); end
        checks++; if (WR_CNT !== 16'd8) begin errors++; $display("FAIL b2b_wr_cnt: got %0d expected 8", WR_CNT); end
        for (int i = 0; i < 8; i++) begin
            CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 3'(i);
            n = 0;
            while (!CMD_READY && n < 10) begin tick; n++; end
            tick;
            CMD_VALID = 1'b0;
            n = 0;
            while (!RSP_VALID && n < 10) begin tick; n++; end
            checks++; if (RSP_DATA !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_rd_data[%0d]: got %0h expected %0h", i, RSP_DATA, 8'h10 + 8'(i)); end
            tick;
        end
        checks++; if (RD_CNT !== 16'd8) begin errors++; $display("FAIL b2b_rd_cnt: got %0d expected 8", RD_CNT); end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL b2b_overlap: got %b expected 0", overlap); end
        checks++; if ({wen_pulses - w0, oen_pulses - o0} !== {32'd8, 32'd8}) begin errors++; $display("FAIL b2b_pulses: got wen=%0d oen=%0d expected 8/8", wen_pulses - w0, oen_pulses - o0); end
    endtask

    task automatic test_reset_mid_read;
        bit seen;
        int n;
        RST = 1'b1; tick; RST = 1'b0; #1;
        RSP_READY = 1'b1;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 3'd2;
        tick;
        CMD_VALID = 1'b0;
        tick;
        RST = 1'b1;
        #1;
        checks++; if ({BUS_OEN, RSP_VALID, RSP_DATA, CMD_READY} !== 11'd0) begin errors++; $display("FAIL mid_rst_drop: got %0h expected 0", {BUS_OEN, RSP_VALID, RSP_DATA, CMD_READY}); end
        tick;
        RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (RSP_VALID) seen = 1'b1;
        end
        checks++; if ({seen, RD_CNT, CMD_READY} !== {1'b0, 16'd0, 1'b1}) begin errors++; $display("FAIL mid_rst_discard: got %0h expected %0h", {seen, RD_CNT, CMD_READY}, {1'b0, 16'd0, 1'b1}); end
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 3'd2;
        tick;
        CMD_VALID = 1'b0;
        n = 0;
        while (!RSP_VALID && n < 10) begin tick; n++; end
        checks++; if ({RSP_VALID, RSP_DATA} !== {1'b1, 8'h12}) begin errors++; $display("FAIL mid_rst_next_read: got %0h expected %0h", {RSP_VALID, RSP_DATA}, {1'b1, 8'h12}); end
        tick;
        checks++; if (RD_CNT !== 16'd1) begin errors++; $display("FAIL mid_rst_next_cnt: got %0d expected 1", RD_CNT); end
    endtask

    task automatic test_counter_wrap;
        int n;
        RST = 1'b1; tick; RST = 1'b0; #1;
        for (int i = 0; i < 17; i++) begin
            c4_valid = 1'b1;
            n = 0;
            while (!c4_ready && n < 10) begin tick; n++; end
            tick;
            c4_valid = 1'b0;
            tick;
            if (i == 14) begin
                checks++; if (c4_wr_cnt !== 4'd15) begin errors++; $display("FAIL wrap_max: got %0d expected 15", c4_wr_cnt); end
            end
            if (i == 15) begin
                checks++; if (c4_wr_cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", c4_wr_cnt); end
            end
        end
        checks++; if (c4_wr_cnt !== 4'd1) begin errors++; $display("FAIL wrap_17: got %0d expected 1", c4_wr_cnt); end
    endtask

    initial begin
        RST = 1'b0;
        CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = 3'd0; CMD_WDATA = 8'h00;
        RSP_READY = 1'b1;
        c4_valid = 1'b0;
        test_reset;
        test_write;
        test_read;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_read;
        test_counter_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
